axi_lite_sram_resp: RTL and testbench

AXI-lite memory responder: the target side of the fetch and load/store request channels issued by the core's IFU and LSU. It answers AR/R reads and AW/W/B writes against an internal word-addressed SRAM array. Fixed, parameterised response latencies let the core's handshake logic be exercised under stall conditions. The read and write paths are independent; one instance serves one initiator.

---
 rtl/axi_lite_sram_resp_if.sv | 48 ++++
 rtl/axi_lite_sram_resp.sv | 249 ++++++++++++++++++++++++
 tb/tb_axi_lite_sram_resp.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_sram_resp_if.sv
`default_nettype none
// ============================================================================
//  Module      : axi_lite_sram_resp_if
//  Description : AXI-lite read (AR/R) and write (AW/W/B) channel bundle for
//                the SRAM responder.
//                master modport - initiator side (drives addresses, data,
//                                 valids on request channels, readys on
//                                 response channels)
//                slave modport  - responder side (the opposite directions)
//  Signals     : araddr/arvalid/arready, rdata/rresp/rvalid/rready,
//                awaddr/awvalid/awready, wdata/wstrb/wvalid/wready,
//                bresp/bvalid/bready
//  Revision    : 1.0 - initial release
// ============================================================================
interface axi_lite_sram_resp_if;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output araddr, arvalid, rready,
    output awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid,
    input  awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arvalid, rready,
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid,
    output awready, wready, bresp, bvalid
  );
endinterface
`default_nettype wire

// File: rtl/axi_lite_sram_resp.sv
`default_nettype none
// ============================================================================
//  Module      : axi_lite_sram_resp
//  Description : AXI-lite target answering reads and writes from an internal
//                word-addressed SRAM with fixed, parameterised response
//                latencies. Read and write paths are fully independent.
//  Ports       : clk  - clock
//                rst  - asynchronous, active-low reset
//                bus  - AXI-lite channels (slave modport of
//                       axi_lite_sram_resp_if)
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_lite_sram_resp #(
  parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned RD_LATENCY  = 1,
  parameter int unsigned WR_LATENCY  = 1
) (
  input  wire logic             clk,
  input  wire logic             rst,
  axi_lite_sram_resp_if.slave   bus
);

  localparam int unsigned IDX_W  = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  RD_LAT = 4'(RD_LATENCY);
  localparam logic [3:0]  WR_LAT = 4'(WR_LATENCY);
  localparam logic [1:0]  OKAY   = 2'b00;
  localparam logic [1:0]  DECERR = 2'b11;

  // --------------------------------------------------------------------------
  // Address decode
  // --------------------------------------------------------------------------
  function automatic logic addr_ok(input logic [31:0] a);
    logic [31:0] off;
    off = a - ADDR_BASE;
    return (a >= ADDR_BASE) && ((off >> 2) < DEPTH_WORDS);
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [31:0] a);
    logic [31:0] off;
    off = a - ADDR_BASE;
    return IDX_W'(off >> 2);
  endfunction

  // Array is never reset; contents survive rst.
  logic [31:0] mem [DEPTH_WORDS];

  // --------------------------------------------------------------------------
  // Read path
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_RESP = 2'd2
  } rd_state_t;

  rd_state_t   rd_state;
  logic [3:0]  rd_cnt;
  logic        ar_ready;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic [1:0]  rd_resp;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_state <= R_IDLE;
      rd_cnt   <= '0;
      ar_ready <= 1'b1;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_resp  <= OKAY;
    end else begin
      case (rd_state)
        R_IDLE: begin
          if (bus.arvalid) begin
            ar_ready <= 1'b0;
            // Array sampled here: a write committing on this same edge is
            // not yet visible to this read.
            if (addr_ok(bus.araddr)) begin
              rd_data <= mem[addr_idx(bus.araddr)];
              rd_resp <= OKAY;
            end else begin
              rd_data <= '0;
              rd_resp <= DECERR;
            end
            rd_cnt <= RD_LAT;
            if (RD_LATENCY == 0) begin
              rd_state <= R_RESP;
              rd_valid <= 1'b1;
            end else begin
              rd_state <= R_WAIT;
            end
          end
        end
        R_WAIT: begin
          rd_cnt <= rd_cnt - 4'd1;
          if (rd_cnt == 4'd1) begin
            rd_state <= R_RESP;
            rd_valid <= 1'b1;
          end
        end
        R_RESP: begin
          if (bus.rready) begin
            rd_state <= R_IDLE;
            rd_valid <= 1'b0;
            ar_ready <= 1'b1;
          end
        end
        default: begin
          rd_state <= R_IDLE;
          rd_valid <= 1'b0;
          ar_ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.arready = ar_ready;
  assign bus.rvalid  = rd_valid;
  assign bus.rdata   = rd_data;
  assign bus.rresp   = rd_resp;

  // --------------------------------------------------------------------------
  // Write path
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_WAIT = 2'd1,
    W_RESP = 2'd2
  } wr_state_t;

  wr_state_t   wr_state;
  logic [3:0]  wr_cnt;
  logic        aw_ready;
  logic        w_ready;
  logic        wr_valid;
  logic [1:0]  wr_resp;
  logic        aw_held;
  logic        w_held;
  logic [31:0] aw_addr_q;
  logic [31:0] w_data_q;
  logic [3:0]  w_strb_q;

  logic        aw_hs;
  logic        w_hs;
  logic        wr_commit;
  logic [31:0] c_addr;
  logic [31:0] c_data;
  logic [3:0]  c_strb;
  logic        c_in_range;
  logic [IDX_W-1:0] c_idx;

  assign aw_hs      = (wr_state == W_IDLE) && aw_ready && bus.awvalid;
  assign w_hs       = (wr_state == W_IDLE) && w_ready  && bus.wvalid;
  // Commit on the edge that completes the AW/W pair, in either order.
  assign wr_commit  = (aw_held || aw_hs) && (w_held || w_hs);
  assign c_addr     = aw_held ? aw_addr_q : bus.awaddr;
  assign c_data     = w_held  ? w_data_q  : bus.wdata;
  assign c_strb     = w_held  ? w_strb_q  : bus.wstrb;
  assign c_in_range = addr_ok(c_addr);
  assign c_idx      = addr_idx(c_addr);

  // The array write lives in the reset-qualified block so a commit edge that
  // coincides with reset assertion never reaches the array.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_state  <= W_IDLE;
      wr_cnt    <= '0;
      aw_ready  <= 1'b1;
      w_ready   <= 1'b1;
      wr_valid  <= 1'b0;
      wr_resp   <= OKAY;
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else begin
      case (wr_state)
        W_IDLE: begin
          if (aw_hs) begin
            aw_held   <= 1'b1;
            aw_addr_q <= bus.awaddr;
            aw_ready  <= 1'b0;
          end
          if (w_hs) begin
            w_held   <= 1'b1;
            w_data_q <= bus.wdata;
            w_strb_q <= bus.wstrb;
            w_ready  <= 1'b0;
          end
          if (wr_commit) begin
            aw_ready <= 1'b0;
            w_ready  <= 1'b0;
            if (c_in_range) begin
              for (int i = 0; i < 4; i++) begin
                if (c_strb[i]) begin
                  mem[c_idx][8*i +: 8] <= c_data[8*i +: 8];
                end
              end
              wr_resp <= OKAY;
            end else begin
              wr_resp <= DECERR;
            end
            wr_cnt <= WR_LAT;
            if (WR_LATENCY == 0) begin
              wr_state <= W_RESP;
              wr_valid <= 1'b1;
            end else begin
              wr_state <= W_WAIT;
            end
          end
        end
        W_WAIT: begin
          wr_cnt <= wr_cnt - 4'd1;
          if (wr_cnt == 4'd1) begin
            wr_state <= W_RESP;
            wr_valid <= 1'b1;
          end
        end
        W_RESP: begin
          if (bus.bready) begin
            wr_state <= W_IDLE;
            wr_valid <= 1'b0;
            aw_ready <= 1'b1;
            w_ready  <= 1'b1;
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
          end
        end
        default: begin
          wr_state <= W_IDLE;
          wr_valid <= 1'b0;
          aw_ready <= 1'b1;
          w_ready  <= 1'b1;
          aw_held  <= 1'b0;
          w_held   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.awready = aw_ready;
  assign bus.wready  = w_ready;
  assign bus.bvalid  = wr_valid;
  assign bus.bresp   = wr_resp;

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_sram_resp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi_lite_sram_resp
//  Description : Directed self-checking bench for axi_lite_sram_resp with
//                default parameters (base 8000_0000, 4096 words, latency 1).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_lite_sram_resp;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  axi_lite_sram_resp_if bus ();

  axi_lite_sram_resp #(
    .ADDR_BASE   (32'h8000_0000),
    .DEPTH_WORDS (4096),
    .RD_LATENCY  (1),
    .WR_LATENCY  (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Drivers -----------------------------------------------------------------
  task automatic do_read(input logic [31:0] a, output logic [31:0] d,
                         output logic [1:0] r, output int lat);
    int n;
    n = 0;
    bus.araddr  = a;
    bus.arvalid = 1'b1;
    @(negedge clk);
    while (!bus.arready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 bus.arvalid = 1'b0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus.rvalid) begin
        lat = k;
        break;
      end
    end
    d = bus.rdata;
    r = bus.rresp;
    if (lat > 0) begin
      bus.rready = 1'b1;
      @(posedge clk);
      #1 bus.rready = 1'b0;
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic [1:0] r,
                          output int lat);
    bus.awaddr  = a;
    bus.wdata   = d;
    bus.wstrb   = s;
    bus.awvalid = 1'b1;
    bus.wvalid  = 1'b1;
    @(posedge clk);
    #1;
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus.bvalid) begin
        lat = k;
        break;
      end
    end
    r = bus.bresp;
    if (lat > 0) begin
      bus.bready = 1'b1;
      @(posedge clk);
      #1 bus.bready = 1'b0;
    end
  endtask

  // Tests -------------------------------------------------------------------
  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    total++; if (bus.arready !== 1'b1) $display("FAIL reset_arready: got %b want 1", bus.arready); else passed++;
    total++; if (bus.awready !== 1'b1) $display("FAIL reset_awready: got %b want 1", bus.awready); else passed++;
    total++; if (bus.wready  !== 1'b1) $display("FAIL reset_wready: got %b want 1", bus.wready); else passed++;
    total++; if (bus.rvalid  !== 1'b0) $display("FAIL reset_rvalid: got %b want 0", bus.rvalid); else passed++;
    total++; if (bus.bvalid  !== 1'b0) $display("FAIL reset_bvalid: got %b want 0", bus.bvalid); else passed++;
    total++; if (bus.rdata !== 32'h0) $display("FAIL reset_rdata: got %h want 00000000", bus.rdata); else passed++;
    total++; if (bus.rresp !== 2'b00 || bus.bresp !== 2'b00) $display("FAIL reset_resp: got r=%b b=%b want 00/00", bus.rresp, bus.bresp); else passed++;
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_full_write();
    logic [31:0] d; logic [1:0] r; int lat;
    do_write(32'h8000_0010, 32'hDEAD_BEEF, 4'b1111, r, lat);
    total++; if (lat !== 2) $display("FAIL full_wr_latency: got %0d want 2", lat); else passed++;
    total++; if (r !== 2'b00) $display("FAIL full_wr_bresp: got %b want 00", r); else passed++;
    do_read(32'h8000_0010, d, r, lat);
    total++; if (lat !== 2) $display("FAIL full_rd_latency: got %0d want 2", lat); else passed++;
    total++; if (d !== 32'hDEAD_BEEF) $display("FAIL full_rd_data: got %h want deadbeef", d); else passed++;
    total++; if (r !== 2'b00) $display("FAIL full_rd_rresp: got %b want 00", r); else passed++;
  endtask

  task automatic test_partial_write();
    logic [31:0] d; logic [1:0] r; int lat;
    do_write(32'h8000_0010, 32'h1122_3344, 4'b0101, r, lat);
    total++; if (r !== 2'b00) $display("FAIL partial_bresp: got %b want 00", r); else passed++;
    do_read(32'h8000_0010, d, r, lat);
    total++; if (d !== 32'hDE22_BE44) $display("FAIL partial_rd_data: got %h want de22be44", d); else passed++;
    do_write(32'h8000_0010, 32'hFFFF_FFFF, 4'b0000, r, lat);
    total++; if (r !== 2'b00) $display("FAIL nostrb_bresp: got %b want 00", r); else passed++;
    do_read(32'h8000_0010, d, r, lat);
    total++; if (d !== 32'hDE22_BE44) $display("FAIL nostrb_rd_data: got %h want de22be44", d); else passed++;
  endtask

  task automatic test_w_before_aw();
    logic [31:0] d; logic [1:0] r; int lat;
    bus.wdata  = 32'hCAFE_F00D;
    bus.wstrb  = 4'b1111;
    bus.wvalid = 1'b1;
    @(posedge clk);
    #1 bus.wvalid = 1'b0;
    total++; if (bus.wready !== 1'b0 || bus.awready !== 1'b1) $display("FAIL wfirst_readys: got w=%b aw=%b want 0/1", bus.wready, bus.awready); else passed++;
    repeat (2) @(posedge clk);
    #1;
    total++; if (bus.wready !== 1'b0 || bus.bvalid !== 1'b0) $display("FAIL wfirst_pending: got wready=%b bvalid=%b want 0/0", bus.wready, bus.bvalid); else passed++;
    bus.awaddr  = 32'h8000_0020;
    bus.awvalid = 1'b1;
    @(posedge clk);
    #1 bus.awvalid = 1'b0;
    total++; if (bus.awready !== 1'b0 || bus.bvalid !== 1'b0) $display("FAIL wfirst_commit: got awready=%b bvalid=%b want 0/0", bus.awready, bus.bvalid); else passed++;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (bus.bvalid !== 1'b1 || bus.bresp !== 2'b00)
        $display("FAIL wfirst_hold%0d: got bvalid=%b bresp=%b want 1/00", i, bus.bvalid, bus.bresp);
      else passed++;
      @(posedge clk);
      #1;
    end
    bus.bready = 1'b1;
    @(posedge clk);
    #1 bus.bready = 1'b0;
    total++; if (bus.bvalid !== 1'b0 || bus.awready !== 1'b1 || bus.wready !== 1'b1) $display("FAIL wfirst_release: got bvalid=%b aw=%b w=%b want 0/1/1", bus.bvalid, bus.awready, bus.wready); else passed++;
    do_read(32'h8000_0020, d, r, lat);
    total++; if (d !== 32'hCAFE_F00D) $display("FAIL wfirst_rd_data: got %h want cafef00d", d); else passed++;
  endtask

  task automatic test_out_of_range();
    logic [31:0] d; logic [1:0] r; int lat;
    do_write(32'h8000_0000, 32'h1111_1111, 4'b1111, r, lat);
    do_write(32'h8000_3FFC, 32'h2222_2222, 4'b1111, r, lat);
    do_read(32'h7FFF_FFFC, d, r, lat);
    total++; if (r !== 2'b11 || d !== 32'h0) $display("FAIL oor_rd_low: got rresp=%b rdata=%h want 11/00000000", r, d); else passed++;
    do_read(32'h8000_4000, d, r, lat);
    total++; if (r !== 2'b11 || d !== 32'h0) $display("FAIL oor_rd_high: got rresp=%b rdata=%h want 11/00000000", r, d); else passed++;
    do_write(32'h7FFF_FFFC, 32'hFFFF_FFFF, 4'b1111, r, lat);
    total++; if (r !== 2'b11) $display("FAIL oor_wr_low: got bresp=%b want 11", r); else passed++;
    do_write(32'h8000_4000, 32'hEEEE_EEEE, 4'b1111, r, lat);
    total++; if (r !== 2'b11) $display("FAIL oor_wr_high: got bresp=%b want 11", r); else passed++;
    do_read(32'h8000_0000, d, r, lat);
    total++; if (d !== 32'h1111_1111) $display("FAIL oor_word0_kept: got %h want 11111111", d); else passed++;
    do_read(32'h8000_3FFC, d, r, lat);
    total++; if (d !== 32'h2222_2222) $display("FAIL oor_lastword_kept: got %h want 22222222", d); else passed++;
  endtask

  task automatic test_hazard();
    logic [31:0] d; logic [1:0] r; int lat;
    do_write(32'h8000_0040, 32'h0000_0000, 4'b1111, r, lat);
    bus.araddr  = 32'h8000_0040;
    bus.arvalid = 1'b1;
    bus.awaddr  = 32'h8000_0040;
    bus.wdata   = 32'h5A5A_5A5A;
    bus.wstrb   = 4'b1111;
    bus.awvalid = 1'b1;
    bus.wvalid  = 1'b1;
    @(posedge clk);
    #1;
    bus.arvalid = 1'b0;
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus.rvalid) begin
        lat = k;
        break;
      end
    end
    total++; if (lat !== 2 || bus.rdata !== 32'h0) $display("FAIL hazard_old_data: got lat=%0d rdata=%h want 2/00000000", lat, bus.rdata); else passed++;
    total++; if (bus.bvalid !== 1'b1 || bus.bresp !== 2'b00) $display("FAIL hazard_bresp: got bvalid=%b bresp=%b want 1/00", bus.bvalid, bus.bresp); else passed++;
    bus.rready = 1'b1;
    bus.bready = 1'b1;
    @(posedge clk);
    #1;
    bus.rready = 1'b0;
    bus.bready = 1'b0;
    do_read(32'h8000_0040, d, r, lat);
    total++; if (d !== 32'h5A5A_5A5A) $display("FAIL hazard_new_data: got %h want 5a5a5a5a", d); else passed++;
  endtask

  task automatic test_reset_midflight();
    logic [31:0] d; logic [1:0] r; int lat;
    do_write(32'h8000_0080, 32'h1357_9BDF, 4'b1111, r, lat);
    bus.araddr  = 32'h8000_0080;
    bus.arvalid = 1'b1;
    bus.awaddr  = 32'h8000_0080;
    bus.awvalid = 1'b1;
    @(posedge clk);
    #1;
    bus.arvalid = 1'b0;
    bus.awvalid = 1'b0;
    total++; if (bus.arready !== 1'b0 || bus.awready !== 1'b0) $display("FAIL mid_pending: got arready=%b awready=%b want 0/0", bus.arready, bus.awready); else passed++;
    rst = 1'b0;
    #1;
    total++; if (bus.rvalid !== 1'b0 || bus.bvalid !== 1'b0) $display("FAIL mid_valids: got rvalid=%b bvalid=%b want 0/0", bus.rvalid, bus.bvalid); else passed++;
    total++; if (bus.arready !== 1'b1 || bus.awready !== 1'b1 || bus.wready !== 1'b1) $display("FAIL mid_readys: got ar=%b aw=%b w=%b want 1/1/1", bus.arready, bus.awready, bus.wready); else passed++;
    total++; if (bus.rdata !== 32'h0) $display("FAIL mid_rdata: got %h want 00000000", bus.rdata); else passed++;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (bus.rvalid !== 1'b0 || bus.bvalid !== 1'b0) $display("FAIL mid_dropped: got rvalid=%b bvalid=%b want 0/0", bus.rvalid, bus.bvalid); else passed++;
    do_read(32'h8000_0080, d, r, lat);
    total++; if (d !== 32'h1357_9BDF || r !== 2'b00) $display("FAIL mid_rd_data: got %h/%b want 13579bdf/00", d, r); else passed++;
  endtask

  initial begin
    bus.araddr  = '0;
    bus.arvalid = 1'b0;
    bus.rready  = 1'b0;
    bus.awaddr  = '0;
    bus.awvalid = 1'b0;
    bus.wdata   = '0;
    bus.wstrb   = '0;
    bus.wvalid  = 1'b0;
    bus.bready  = 1'b0;
    test_reset();
    test_full_write();
    test_partial_write();
    test_w_before_aw();
    test_out_of_range();
    test_hazard();
    test_reset_midflight();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
